// File: rtl/frame_rx_parser_pkg.sv
// Shared Modbus RTU constants, FSM encoding and the byte-serial CRC-16/Modbus step
// used by the request parser and the response stage.
package frame_rx_parser_pkg;

   localparam logic [7:0] FC_READ_HOLDING = 8'h03;
   localparam logic [7:0] FC_READ_INPUT   = 8'h04;

   localparam logic [7:0] EXC_NONE             = 8'h00;
   localparam logic [7:0] EXC_ILLEGAL_FUNCTION = 8'h01;
   localparam logic [7:0] EXC_ILLEGAL_ADDRESS  = 8'h02;
   localparam logic [7:0] EXC_ILLEGAL_VALUE    = 8'h03;

   localparam logic [15:0] CRC_POLY = 16'hA001;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // A read request is 8 bytes; the last two are the CRC and only feed the CRC engine.
   localparam logic [3:0]  FRAME_LEN     = 4'd8;
   localparam logic [3:0]  HEADER_LEN    = 4'd6;
   localparam int unsigned HEADER_BYTES  = 6;
   localparam logic [7:0]  MAX_QUANTITY  = 8'd125;

   typedef enum logic [2:0] {
      ST_SYNC  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_RECV  = 3'd2,
      ST_CHECK = 3'd3,
      ST_ISSUE = 3'd4
   } state_e;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
      logic [15:0] crc;
      crc = crc_in ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         crc = crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
      end
      return crc;
   endfunction

endpackage

// File: rtl/frame_rx_parser_crc16_modbus.sv
// Byte-serial CRC-16/Modbus register; clear and byte strobe may coincide, in which
// case the byte is folded into a freshly seeded CRC.
module crc16_modbus
   import frame_rx_parser_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   logic [15:0] crc_q, crc_d, crc_base;

   always_comb begin
      crc_base = clear ? CRC_INIT : crc_q;
      crc_d    = crc_base;
      if (byte_valid) begin
         crc_d = crc16_byte(crc_base, data_in);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_out = crc_q;

endmodule

// File: rtl/frame_rx_parser.sv
// Modbus RTU request parser: delimits frames by T3.5 line silence, validates length,
// CRC and address, and hands a decoded read request (or exception) to the response stage.
module frame_rx_parser
   import frame_rx_parser_pkg::*;
#(
   parameter logic [7:0]  DEV_ADDR   = 8'h01,
   parameter int unsigned T35_CYCLES = 'd1750,
   parameter int unsigned ADDR_SPACE = 'd256
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        resp_busy,
   output logic        tx_start,
   output logic [7:0]  func_code,
   output logic [15:0] start_addr,
   output logic [7:0]  tx_quantity,
   output logic [7:0]  exc_code,
   output logic        crc_err
);

   localparam int unsigned      GAP_W      = $clog2(T35_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(T35_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(T35_CYCLES);
   localparam logic [16:0]      ADDR_LIMIT = 17'(ADDR_SPACE);

   state_e           state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
   logic [3:0]       cnt_q, cnt_d;
   logic             overrun_q, overrun_d;
   logic             late_q, late_d;
   logic             crc_err_q, crc_err_d;
   logic [7:0]       func_q, func_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       qty_q, qty_d;
   logic [7:0]       exc_q, exc_d;
   logic [7:0]       frame_q [HEADER_BYTES];

   logic        take_first, take_next, wr_en;
   logic [2:0]  wr_idx;
   logic        crc_clear, crc_strobe;
   logic [15:0] crc_val;
   logic        gap_expired, frame_ok, issue;
   logic [15:0] req_addr;
   logic [16:0] addr_end;
   logic [7:0]  req_exc;

   crc16_modbus u_crc (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .clear      (crc_clear),
      .byte_valid (crc_strobe),
      .data_in    (rx_data),
      .crc_out    (crc_val)
   );

   always_comb begin
      req_addr = {frame_q[2], frame_q[3]};
      addr_end = {1'b0, req_addr} + {9'd0, frame_q[5]};
      if (frame_q[1] != FC_READ_HOLDING && frame_q[1] != FC_READ_INPUT) begin
         req_exc = EXC_ILLEGAL_FUNCTION;
      end else if (frame_q[4] != 8'h00 || frame_q[5] == 8'h00 || frame_q[5] > MAX_QUANTITY) begin
         req_exc = EXC_ILLEGAL_VALUE;
      end else if (addr_end > ADDR_LIMIT) begin
         req_exc = EXC_ILLEGAL_ADDRESS;
      end else begin
         req_exc = EXC_NONE;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      cnt_d       = cnt_q;
      overrun_d   = overrun_q;
      late_d      = late_q;
      func_d      = func_q;
      addr_d      = addr_q;
      qty_d       = qty_q;
      exc_d       = exc_q;
      crc_err_d   = 1'b0;
      take_first  = 1'b0;
      take_next   = 1'b0;
      issue       = 1'b0;
      gap_inc     = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
      gap_expired = (gap_q >= GAP_LAST);
      frame_ok    = (cnt_q == FRAME_LEN) && !overrun_q;

      case (state_q)
         ST_SYNC: begin
            if (rx_valid) begin
               gap_d = '0;
            end else if (gap_expired) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_inc;
            end
         end
         ST_IDLE: begin
            if (rx_valid) begin
               take_first = 1'b1;
               state_d    = ST_RECV;
            end
         end
         ST_RECV: begin
            // A byte landing on the silence boundary is dropped and forces a resync.
            if (gap_expired) begin
               late_d  = rx_valid;
               gap_d   = gap_inc;
               state_d = ST_CHECK;
            end else if (rx_valid) begin
               take_next = 1'b1;
            end else begin
               gap_d = gap_inc;
            end
         end
         ST_CHECK: begin
            crc_err_d = frame_ok && (crc_val != 16'h0000);
            issue     = frame_ok && (crc_val == 16'h0000) && (frame_q[0] == DEV_ADDR)
                        && !resp_busy && !late_q;
            cnt_d     = '0;
            overrun_d = 1'b0;
            late_d    = 1'b0;
            state_d   = issue ? ST_ISSUE : ST_IDLE;
            if (issue) begin
               func_d = frame_q[1];
               addr_d = req_addr;
               qty_d  = frame_q[5];
               exc_d  = req_exc;
            end
            // The next frame may start right after T3.5 silence, i.e. during CHECK.
            if (late_q) begin
               gap_d   = '0;
               state_d = ST_SYNC;
            end else if (rx_valid) begin
               take_first = 1'b1;
               if (!issue) begin
                  state_d = ST_RECV;
               end
            end else begin
               gap_d = gap_inc;
            end
         end
         ST_ISSUE: begin
            if (rx_valid) begin
               if (cnt_q == '0) begin
                  take_first = 1'b1;
               end else begin
                  take_next = 1'b1;
               end
            end else begin
               gap_d = gap_inc;
            end
            state_d = (rx_valid || cnt_q != '0) ? ST_RECV : ST_IDLE;
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase

      wr_en      = take_first || (take_next && cnt_q < HEADER_LEN);
      wr_idx     = take_first ? 3'd0 : cnt_q[2:0];
      crc_clear  = take_first;
      crc_strobe = take_first || take_next;
      if (take_first) begin
         cnt_d     = 4'd1;
         overrun_d = 1'b0;
         gap_d     = '0;
      end else if (take_next) begin
         gap_d = '0;
         if (cnt_q < FRAME_LEN) begin
            cnt_d = cnt_q + 4'd1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= ST_SYNC;
         gap_q     <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
         late_q    <= 1'b0;
         crc_err_q <= 1'b0;
         func_q    <= '0;
         addr_q    <= '0;
         qty_q     <= '0;
         exc_q     <= '0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
         late_q    <= late_d;
         crc_err_q <= crc_err_d;
         func_q    <= func_d;
         addr_q    <= addr_d;
         qty_q     <= qty_d;
         exc_q     <= exc_d;
      end
   end

   // NOTE: the header buffer has no reset; CHECK only reads it once a full frame has rewritten it.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         frame_q[wr_idx] <= rx_data;
      end
   end

   assign tx_start    = (state_q == ST_ISSUE);
   assign crc_err     = crc_err_q;
   assign func_code   = func_q;
   assign start_addr  = addr_q;
   assign tx_quantity = qty_q;
   assign exc_code    = exc_q;

endmodule

// File: tb/tb_frame_rx_parser.sv
// Scoreboard bench for frame_rx_parser: stimulus pushes expected pulses (with their
// due time), a negedge monitor pops and compares every tx_start / crc_err it sees.
module tb_frame_rx_parser;

   localparam int  T35 = 20;
   localparam time P   = 10;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        resp_busy = 1'b0;
   logic        tx_start, crc_err;
   logic [7:0]  func_code, tx_quantity, exc_code;
   logic [15:0] start_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      bit          is_tx;
      logic [7:0]  func;
      logic [15:0] start;
      logic [7:0]  qty;
      logic [7:0]  exc;
      time         t_due;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [7:0] fb [0:8];
   time        t_last;

   frame_rx_parser #(
      .DEV_ADDR   (8'h01),
      .T35_CYCLES (T35),
      .ADDR_SPACE (256)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .resp_busy   (resp_busy),
      .tx_start    (tx_start),
      .func_code   (func_code),
      .start_addr  (start_addr),
      .tx_quantity (tx_quantity),
      .exc_code    (exc_code),
      .crc_err     (crc_err)
   );

   initial forever #(P/2) clk_in = ~clk_in;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_crc(input int len);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < len; i++) begin
         c = c ^ {8'h00, fb[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   task automatic make_frame(input logic [7:0] a, f, sh, sl, qh, ql);
      logic [15:0] c;
      fb[0] = a; fb[1] = f; fb[2] = sh; fb[3] = sl; fb[4] = qh; fb[5] = ql;
      c = model_crc(6);
      fb[6] = c[7:0];
      fb[7] = c[15:8];
      fb[8] = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic send_frame(input int len);
      for (int i = 0; i < len; i++) begin
         rx_data  = fb[i];
         rx_valid = 1'b1;
         @(posedge clk_in);
         t_last = $time;
         #1;
         rx_valid = 1'b0;
      end
   endtask

   task automatic expect_pulse(input string name, input bit is_tx, input logic [7:0] f,
                               input logic [15:0] s, input logic [7:0] q, input logic [7:0] e);
      exp_t x;
      x.name = name; x.is_tx = is_tx; x.func = f; x.start = s; x.qty = q; x.exc = e;
      x.t_due = t_last + (T35 + 1) * P + P / 2;
      sb_q.push_back(x);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 2 * T35 + 20) begin
         @(posedge clk_in);
         n++;
      end
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected pulse(s) never seen", name, sb_q.size());
         sb_q.delete();
      end
      idle(4);
   endtask

   always @(negedge clk_in) begin
      if (!rst_in && (tx_start || crc_err)) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: tx_start=%0b crc_err=%0b func=%h start=%h qty=%h exc=%h at %0t, none expected",
                     tx_start, crc_err, func_code, start_addr, tx_quantity, exc_code, $time);
         end else begin
            mon_e = sb_q.pop_front();
            if (tx_start !== mon_e.is_tx || crc_err !== !mon_e.is_tx || $time != mon_e.t_due ||
                (mon_e.is_tx && {func_code, start_addr, tx_quantity, exc_code} !==
                                {mon_e.func, mon_e.start, mon_e.qty, mon_e.exc})) begin
               errors++;
               $display("FAIL %s: got tx_start=%0b crc_err=%0b func=%h start=%h qty=%h exc=%h at %0t; expected tx=%0b func=%h start=%h qty=%h exc=%h at %0t",
                        mon_e.name, tx_start, crc_err, func_code, start_addr, tx_quantity, exc_code, $time,
                        mon_e.is_tx, mon_e.func, mon_e.start, mon_e.qty, mon_e.exc, mon_e.t_due);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 rst_in = 1'b1;
      @(posedge clk_in); #1;
      check("reset_pulses", {46'd0, tx_start, crc_err}, 48'd0);
      check("reset_fields", {8'd0, func_code, start_addr, tx_quantity, exc_code}, 48'd0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      idle(T35 + 2);

      // Reference frame with its published CRC bytes.
      fb[0] = 8'h01; fb[1] = 8'h03; fb[2] = 8'h00; fb[3] = 8'h00;
      fb[4] = 8'h00; fb[5] = 8'h0A; fb[6] = 8'hC5; fb[7] = 8'hCD;
      send_frame(8);
      expect_pulse("ref_frame", 1'b1, 8'h03, 16'h0000, 8'h0A, 8'h00);
      wait_drain("ref_frame_drain");

      fb[7] = 8'hCC;
      send_frame(8);
      expect_pulse("bad_crc", 1'b0, 8'h00, 16'h0000, 8'h00, 8'h00);
      wait_drain("bad_crc_drain");
      check("hold_after_crc_err", {8'd0, func_code, start_addr, tx_quantity, exc_code},
            {8'd0, 8'h03, 16'h0000, 8'h0A, 8'h00});

      make_frame(8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A);
      send_frame(8);
      idle(T35 + 10);

      make_frame(8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03);
      send_frame(8);
      expect_pulse("bad_func", 1'b1, 8'h06, 16'h0001, 8'h03, 8'h01);
      wait_drain("bad_func_drain");

      make_frame(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
      send_frame(8);
      expect_pulse("qty_zero", 1'b1, 8'h03, 16'h0000, 8'h00, 8'h03);
      wait_drain("qty_zero_drain");

      make_frame(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h7E);
      send_frame(8);
      expect_pulse("qty_126", 1'b1, 8'h03, 16'h0000, 8'h7E, 8'h03);
      wait_drain("qty_126_drain");

      make_frame(8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h7D);
      send_frame(8);
      expect_pulse("qty_125", 1'b1, 8'h04, 16'h0000, 8'h7D, 8'h00);
      wait_drain("qty_125_drain");

      make_frame(8'h01, 8'h03, 8'h00, 8'hFA, 8'h00, 8'h0A);
      send_frame(8);
      expect_pulse("addr_over", 1'b1, 8'h03, 16'h00FA, 8'h0A, 8'h02);
      wait_drain("addr_over_drain");

      resp_busy = 1'b1;
      make_frame(8'h01, 8'h04, 8'h00, 8'h10, 8'h00, 8'h02);
      send_frame(8);
      idle(T35 + 10);
      resp_busy = 1'b0;
      check("hold_after_busy", {8'd0, func_code, start_addr, tx_quantity, exc_code},
            {8'd0, 8'h03, 16'h00FA, 8'h0A, 8'h02});

      make_frame(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A);
      send_frame(9);
      idle(T35 + 10);

      make_frame(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A);
      send_frame(4);
      rst_in = 1'b1;
      #1;
      check("midframe_reset_pulses", {46'd0, tx_start, crc_err}, 48'd0);
      check("midframe_reset_fields", {8'd0, func_code, start_addr, tx_quantity, exc_code}, 48'd0);
      idle(2);
      rst_in = 1'b0;
      idle(T35 + 2);
      make_frame(8'h01, 8'h04, 8'h00, 8'h05, 8'h00, 8'h07);
      send_frame(8);
      expect_pulse("after_reset", 1'b1, 8'h04, 16'h0005, 8'h07, 8'h00);
      wait_drain("after_reset_drain");

      make_frame(8'h01, 8'h03, 8'h00, 8'h20, 8'h00, 8'h10);
      send_frame(8);
      expect_pulse("pair_a", 1'b1, 8'h03, 16'h0020, 8'h10, 8'h00);
      idle(T35);
      make_frame(8'h01, 8'h04, 8'h00, 8'hF0, 8'h00, 8'h10);
      send_frame(8);
      expect_pulse("pair_b_addr_edge", 1'b1, 8'h04, 16'h00F0, 8'h10, 8'h00);
      wait_drain("pair_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
